// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl
// Front-end controller for a simple dual-port RAM (one registered read port,
// one write port). It arbitrates two read requesters, buffers writes in a
// 2-entry in-order FIFO, and forwards buffered write data to reads so that
// the RAM behaves as if every accepted write took effect immediately.
// A full-table sweep writes INIT_NUM to every entry after reset and on
// flush_req. No request is accepted while the sweep runs.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   flush_req / flush_busy       start a sweep / sweep in progress
//   r0_valid, r0_addr, r0_ready  read request, requester 0
//   r1_valid, r1_addr, r1_ready  read request, requester 1
//   r0_rvalid, r1_rvalid, rdata  read responses on a shared data bus
//   w_valid, w_addr, w_data,     write request
//   w_ready
//   ram_raddr, ram_enb, ram_dout RAM read port (ram_dout valid one cycle
//                                after ram_enb)
//   ram_waddr, ram_din, ram_we   RAM write port
module ram_port_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2,
    parameter int INIT_NUM   = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush_req,
    output logic                  flush_busy,
    input  logic                  r0_valid,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    output logic                  r0_ready,
    input  logic                  r1_valid,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic                  r1_ready,
    output logic                  r0_rvalid,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  w_valid,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_ready,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_enb,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [DATA_WIDTH-1:0] INIT_VAL  = DATA_WIDTH'(INIT_NUM);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_next;
    // The state register comes out of reset already in FLUSH; run holds the
    // sweep (and every output it drives) quiet until the first clock edge
    // after rstn is released, so the outputs read 0 throughout reset.
    logic                    run;

    // Write FIFO
    logic [ADDR_WIDTH-1:0]   fifo_addr [2];
    logic [DATA_WIDTH-1:0]   fifo_data [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;
    logic                    push, pop, clear;
    logic                    young_idx;

    // Read path
    logic                    rr_ptr;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic                    fwd_hit, fwd_hit_q;
    logic [DATA_WIDTH-1:0]   fwd_data, fwd_data_q;

    // ------------------------------------------------------------------
    // State register and sweep counter
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FLUSH;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            run   <= 1'b1;
        end
    end

    // Next state plus write-port outputs (sweep or FIFO drain)
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value held and infer a latch.
        state_next = state;
        cnt_next   = cnt;
        flush_busy = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_din    = '0;
        case (state)
            FLUSH: begin
                if (run) begin
                    flush_busy = 1'b1;
                    ram_we     = 1'b1;
                    ram_waddr  = cnt;
                    ram_din    = INIT_VAL;
                    if (flush_req) begin
                        cnt_next = '0;
                    end else if (cnt == LAST_ADDR) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (count != 2'd0) begin
                    ram_we    = 1'b1;
                    ram_waddr = fifo_addr[rd_ptr];
                    ram_din   = fifo_data[rd_ptr];
                end
                if (flush_req) begin
                    state_next = FLUSH;
                    cnt_next   = '0;
                end
            end
            default: state_next = FLUSH;
        endcase
    end

    // ------------------------------------------------------------------
    // Write FIFO: 2 entries, in order, drained one per cycle in IDLE
    // ------------------------------------------------------------------
    // w_ready looks only at the registered count: a full FIFO refuses a
    // write even in a cycle where its head drains.
    assign w_ready = (state == IDLE) && (count != 2'd2);
    assign push    = w_valid && w_ready;
    assign pop     = (state == IDLE) && (count != 2'd0);
    // Entering a sweep throws away everything buffered, including a write
    // accepted in that same cycle.
    assign clear   = (state == IDLE) && flush_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the count alone says which entries
    // are meaningful, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= w_addr;
            fifo_data[wr_ptr] <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // Read arbitration: one grant per cycle, round-robin on contention
    // ------------------------------------------------------------------
    assign r0_ready  = (state == IDLE) && r0_valid && (!r1_valid || !rr_ptr);
    assign r1_ready  = (state == IDLE) && r1_valid && (!r0_valid ||  rr_ptr);
    assign ram_enb   = r0_ready || r1_ready;
    assign gnt_addr  = r0_ready ? r0_addr : r1_addr;
    assign ram_raddr = ram_enb ? gnt_addr : '0;

    // Forwarding: the entry written most recently wins. The FIFO contents
    // are those before this cycle's push, so a write accepted alongside the
    // read stays invisible to it.
    assign young_idx = ~wr_ptr;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if ((count != 2'd0) && (fifo_addr[young_idx] == gnt_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = fifo_data[young_idx];
        end else if ((count == 2'd2) && (fifo_addr[rd_ptr] == gnt_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr     <= 1'b0;
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            // Flip only after a contested cycle so the loser wins next time.
            if ((state == IDLE) && r0_valid && r1_valid) rr_ptr <= ~rr_ptr;
            r0_rvalid  <= r0_ready;
            r1_rvalid  <= r1_ready;
            fwd_hit_q  <= fwd_hit;
            fwd_data_q <= fwd_data;
        end
    end

    assign rdata = (r0_rvalid || r1_rvalid) ? (fwd_hit_q ? fwd_data_q : ram_dout) : '0;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Testbench for ram_port_ctrl (ADDR_WIDTH=4, DATA_WIDTH=2, INIT_NUM=1).
// The bench supplies a registered RAM and a reference model that treats the
// controller as a plain memory where each accepted write takes effect at once
// (read-first), plus the sweep schedule, the round-robin rule and the
// in-order write-port drain.
module tb_ram_port_ctrl;

    localparam int AW = 4;
    localparam int DW = 2;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] INIT_V = 2'd1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush_req, flush_busy;
    logic          r0_valid, r0_ready, r1_valid, r1_ready;
    logic [AW-1:0] r0_addr, r1_addr;
    logic          r0_rvalid, r1_rvalid;
    logic [DW-1:0] rdata;
    logic          w_valid, w_ready;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic          ram_enb, ram_we;
    logic [DW-1:0] ram_dout, ram_din;

    ram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_NUM(1)) dut (
        .clk(clk), .rstn(rstn),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid), .rdata(rdata),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
        .ram_raddr(ram_raddr), .ram_enb(ram_enb), .ram_dout(ram_dout),
        .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_we(ram_we)
    );

    always #5 clk = ~clk;

    // Registered RAM attached to the controller
    logic [DW-1:0] ram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = 2'd3;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_we)  ram_mem[ram_waddr] <= ram_din;
        if (ram_enb) ram_dout <= ram_mem[ram_raddr];
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] mem_m [DEPTH];   // contents as seen by readers
    wr_t           wq [$];          // writes not yet on the RAM write port
    int            sweep_addr;      // next sweep address, -1 when idle
    bit            prefer_r1;       // who wins the next contested cycle
    bit            exp_r0v, exp_r1v;
    logic [DW-1:0] exp_rdata;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        sweep_addr = -1;
        prefer_r1  = 1'b0;
        exp_r0v    = 1'b0;
        exp_r1v    = 1'b0;
        exp_rdata  = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT_V;
    endtask

    // Called at a falling edge: compare every output against the model for
    // the current cycle, then advance the model past the coming rising edge.
    task automatic check_and_update();
        bit g0, g1, idle;
        int qsize;
        g0    = 1'b0;
        g1    = 1'b0;
        idle  = (sweep_addr < 0);
        qsize = wq.size();
        if (idle) begin
            if (r0_valid && r1_valid) begin
                if (prefer_r1) g1 = 1'b1;
                else           g0 = 1'b1;
            end else if (r0_valid) begin
                g0 = 1'b1;
            end else if (r1_valid) begin
                g1 = 1'b1;
            end
        end

        check("r0_rvalid",  32'(r0_rvalid),  32'(exp_r0v));
        check("r1_rvalid",  32'(r1_rvalid),  32'(exp_r1v));
        check("rdata",      32'(rdata),      32'(exp_rdata));
        check("r0_ready",   32'(r0_ready),   32'(g0));
        check("r1_ready",   32'(r1_ready),   32'(g1));
        check("ram_enb",    32'(ram_enb),    32'(g0 || g1));
        if (g0) check("ram_raddr", 32'(ram_raddr), 32'(r0_addr));
        if (g1) check("ram_raddr", 32'(ram_raddr), 32'(r1_addr));
        check("w_ready",    32'(w_ready),    32'(idle && qsize < 2));
        check("flush_busy", 32'(flush_busy), 32'(!idle));
        check("ram_we",     32'(ram_we),     32'(!idle || qsize > 0));
        if (!idle) begin
            check("sweep_waddr", 32'(ram_waddr), 32'(sweep_addr));
            check("sweep_din",   32'(ram_din),   32'(INIT_V));
        end else if (qsize > 0) begin
            check("drain_waddr", 32'(ram_waddr), 32'(wq[0].a));
            check("drain_din",   32'(ram_din),   32'(wq[0].d));
        end

        // Read-first: responses reflect contents before this cycle's write.
        exp_r0v   = g0;
        exp_r1v   = g1;
        exp_rdata = g0 ? mem_m[r0_addr] : (g1 ? mem_m[r1_addr] : '0);
        if (idle && r0_valid && r1_valid) prefer_r1 = !prefer_r1;
        if (idle && qsize > 0) void'(wq.pop_front());
        if (idle && w_valid && qsize < 2) begin
            wq.push_back('{a: w_addr, d: w_data});
            mem_m[w_addr] = w_data;
        end
        if (idle) begin
            if (flush_req) begin
                sweep_addr = 0;
                wq.delete();
                for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT_V;
            end
        end else if (flush_req) begin
            sweep_addr = 0;
        end else if (sweep_addr == DEPTH - 1) begin
            sweep_addr = -1;
        end else begin
            sweep_addr++;
        end
    endtask

    // One clock cycle; inputs are already driven (just after a rising edge).
    task automatic step();
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flush_busy"}, 32'(flush_busy), 0);
        check({tag, "_r0_ready"},   32'(r0_ready),   0);
        check({tag, "_r1_ready"},   32'(r1_ready),   0);
        check({tag, "_w_ready"},    32'(w_ready),    0);
        check({tag, "_r0_rvalid"},  32'(r0_rvalid),  0);
        check({tag, "_r1_rvalid"},  32'(r1_rvalid),  0);
        check({tag, "_rdata"},      32'(rdata),      0);
        check({tag, "_ram_enb"},    32'(ram_enb),    0);
        check({tag, "_ram_raddr"},  32'(ram_raddr),  0);
        check({tag, "_ram_we"},     32'(ram_we),     0);
        check({tag, "_ram_waddr"},  32'(ram_waddr),  0);
        check({tag, "_ram_din"},    32'(ram_din),    0);
    endtask

    // After reset release: wait (bounded) for the first sweep write, which
    // must be address 0; the caller steps through the remaining 15.
    task automatic expect_sweep(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                found      = 1'b1;
                sweep_addr = 0;
                check_and_update();
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_sweep_start"}, 32'(found), 1);
    endtask

    task automatic idle_inputs();
        flush_req = 1'b0;
        r0_valid  = 1'b0; r0_addr = '0;
        r1_valid  = 1'b0; r1_addr = '0;
        w_valid   = 1'b0; w_addr  = '0; w_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        idle_inputs();
        model_reset();

        // Reset: outputs quiet even with requests pending
        r0_valid = 1'b1; r0_addr = 4'd9; w_valid = 1'b1; w_addr = 4'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        idle_inputs();

        // Boot sweep: addresses 0..15 with data 1, then IDLE with w_ready=1
        rstn = 1'b1;
        expect_sweep("boot");
        repeat (DEPTH - 1) step();
        step();

        // Both requesters held high: grants alternate r0, r1, r0, ...
        r0_valid = 1'b1; r0_addr = 4'd3;
        r1_valid = 1'b1; r1_addr = 4'd7;
        repeat (6) step();
        idle_inputs();
        step();

        // Same-cycle read sees the old value; next-cycle read is forwarded
        w_valid = 1'b1; w_addr = 4'd5; w_data = 2'd2;
        r0_valid = 1'b1; r0_addr = 4'd5;
        step();
        check("same_cycle_read", 32'(rdata), 1);
        idle_inputs();
        r1_valid = 1'b1; r1_addr = 4'd5;
        step();
        check("forwarded_read", 32'(rdata), 2);
        idle_inputs();
        r0_valid = 1'b1; r0_addr = 4'd5;
        step();
        check("ram_read_after_drain", 32'(rdata), 2);
        idle_inputs();
        step();

        // Back-to-back writes across a flush: refused once sweeping,
        // buffered ones discarded, table reads 1 afterwards
        w_valid = 1'b1; w_addr = 4'd10; w_data = 2'd2;
        step();
        w_addr = 4'd11; w_data = 2'd3; flush_req = 1'b1;
        step();
        flush_req = 1'b0; w_addr = 4'd12; w_data = 2'd0;
        step();
        check("w_ready_in_flush", 32'(w_ready), 0);
        w_valid = 1'b0;
        repeat (DEPTH) step();
        for (int a = 10; a <= 12; a++) begin
            r0_valid = 1'b1; r0_addr = AW'(a);
            step();
            check("read_after_flush", 32'(rdata), 1);
        end
        idle_inputs();
        step();

        // flush_req at sweep counter 9 restarts the sweep at 0
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int g = 0; g < 40 && sweep_addr != 9; g++) step();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (DEPTH) step();
        step();

        // Reset at sweep counter 6: outputs drop at once, sweep restarts at 0
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int g = 0; g < 40 && sweep_addr != 6; g++) step();
        r0_valid = 1'b1; r0_addr = 4'd2; w_valid = 1'b1; w_addr = 4'd2;
        @(negedge clk);
        check("pre_reset_waddr", 32'(ram_waddr), 6);
        rstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("held_reset");
        idle_inputs();
        rstn = 1'b1;
        expect_sweep("rereset");
        repeat (DEPTH - 1) step();
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            flush_req = ($urandom_range(0, 59) == 0);
            r0_valid  = $urandom_range(0, 1) == 1;
            r1_valid  = $urandom_range(0, 1) == 1;
            w_valid   = $urandom_range(0, 2) != 0;
            r0_addr   = AW'($urandom_range(0, 3));
            r1_addr   = AW'($urandom_range(0, DEPTH - 1));
            w_addr    = AW'($urandom_range(0, 3));
            w_data    = DW'($urandom_range(0, 3));
            step();
        end
        idle_inputs();
        repeat (DEPTH + 2) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM address width (2^ADDR_WIDTH entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 2, RAM data width.
REQ-003 SHALL have parameter INIT_NUM, default 0, value written to every entry during a sweep.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rstn  in  1  asynchronous active-low reset.
REQ-005 SHALL have: flush_req  in  1  start a full-table sweep; flush_busy  out  1  sweep in progress.
REQ-006 SHALL have: r0_valid  in  1; r0_addr  in  ADDR_WIDTH; r0_ready  out  1  read-request handshake, requester 0.
REQ-007 SHALL have: r1_valid  in  1; r1_addr  in  ADDR_WIDTH; r1_ready  out  1  read-request handshake, requester 1.
REQ-008 SHALL have: r0_rvalid  out  1; r1_rvalid  out  1; rdata  out  DATA_WIDTH  read response, shared data bus.
REQ-009 SHALL have: w_valid  in  1; w_addr  in  ADDR_WIDTH; w_data  in  DATA_WIDTH; w_ready  out  1  write handshake.
REQ-010 SHALL have RAM-side ports: ram_raddr  out  ADDR_WIDTH; ram_enb  out  1; ram_dout  in  DATA_WIDTH (registered, valid one cycle after ram_enb); ram_waddr  out  ADDR_WIDTH; ram_din  out  DATA_WIDTH; ram_we  out  1.

Function
REQ-011 SHALL implement FSM states IDLE and FLUSH; transitions: FLUSH->IDLE when the sweep counter writes entry 2^ADDR_WIDTH-1; IDLE->FLUSH on flush_req=1.
REQ-012 SHALL, in FLUSH, write INIT_NUM to address = sweep counter each cycle (ram_we=1) and increment the counter by 1; flush_busy=1; r0_ready=r1_ready=w_ready=0.
REQ-013 SHALL restart the sweep counter at 0 when flush_req=1 arrives during FLUSH.
REQ-014 SHALL, on entering FLUSH from IDLE, discard all write-buffer entries; any read responses already in flight complete normally on the following cycle.
REQ-015 SHALL buffer writes in a 2-entry in-order FIFO; handshake when w_valid && w_ready; w_ready = IDLE && FIFO not full (registered count; no same-cycle full-and-drain acceptance).
REQ-016 SHALL, in IDLE with FIFO non-empty, drain the head entry to the RAM write port (ram_we=1) every cycle, one entry per cycle.
REQ-017 SHALL grant at most one read per cycle in IDLE; ready is combinational from valid and a round-robin pointer; a lone requester is granted immediately.
REQ-018 SHALL toggle the round-robin pointer only after a cycle in which both requesters were valid, so that the non-granted requester wins next; the pointer resets to requester 0.
REQ-019 SHALL drive ram_enb=1 and ram_raddr=granted address in the grant cycle; ram_enb=0 otherwise.
REQ-020 SHALL pulse the granted requester's rvalid for exactly one cycle, one cycle after the handshake.
REQ-021 SHALL forward on read: if the granted address matches any FIFO entry in the grant cycle (including the head being drained that cycle), rdata returns the youngest matching entry's data; otherwise rdata = ram_dout.
REQ-022 SHALL order a read and a write accepted in the same cycle read-first: the read does not see that write.
REQ-023 SHALL drive rdata = 0 when no rvalid is asserted.

Reset
REQ-024 SHALL, on rstn=0, asynchronously clear: FIFO empty, counter 0, RR pointer 0, all rvalid 0, ram_we 0, ram_enb 0, all ready outputs 0.
REQ-025 SHALL enter FLUSH on reset release, with flush_busy=1, and sweep the full table before any request is accepted.
REQ-026 SHALL abort any sweep and discard buffered writes when reset asserts mid-operation; the post-release sweep starts at 0.

Verification
REQ-027 SHALL verify with ADDR_WIDTH=4, INIT_NUM=1: release reset -> 16 consecutive ram_we cycles, addresses 0..15, ram_din=1; flush_busy falls after address 15; w_ready rises the next cycle.
REQ-028 SHALL verify: r0_valid and r1_valid held high with addresses 3 and 7 -> grants alternate r0,r1,r0,...; each rvalid pulses one cycle after its grant.
REQ-029 SHALL verify: write addr 5 data 2, read addr 5 the next cycle -> rdata=2 via forwarding; a read of addr 5 issued in the same cycle as the write -> rdata = old value 1.
REQ-030 SHALL verify: three back-to-back writes with the drain blocked by flush -> w_ready=0 after two entries; a flush_req discards them; reads after the sweep return 1.
REQ-031 SHALL verify: flush_req pulsed at sweep counter=9 -> the counter restarts at 0 and 16 further writes occur.
REQ-032 SHALL verify: rstn asserted at sweep counter=6 -> all outputs 0 immediately; after release, the sweep restarts at address 0.
